// File: rtl/audio_pkg.sv
// Shared types and constants for the codec DAC transmit path.
package audio_pkg;

  localparam int AUDIO_W     = 16;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } dac_tx_state_t;

endpackage

// File: rtl/dstream.sv
// Sample stream handshake: a word moves on every clk edge where valid && ready are both high;
// the master holds data/valid stable until that edge, and ready may depend only on sink state.
interface dstream #(
  parameter int N = 16
);

  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for a slow codec-driven signal, with registered rise/fall strobes.
module sync_edge
  import audio_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    last_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~last_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/audio_codec_dac_tx.sv
// I2S serialiser for the WM8731 DAC: one mono sample per LRC frame, sent on both channels,
// with the codec supplying BCLK and DACLRCK.
module audio_codec_dac_tx
  import audio_pkg::*;
#(
  parameter int N           = AUDIO_W,
  parameter int BITS_PER_CH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bclk,
  input  logic          daclrc,
  dstream.slave         audio_in,
  output logic          dacdat,
  output logic          underflow,
  output dac_tx_state_t dbg_state
);

  localparam int CNT_W = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;

  logic bclk_fall, bclk_rise_unused, lrc_rise, lrc_fall, lrc_edge, accept;

  dac_tx_state_t state_q, state_d;
  logic [N-1:0]  hold_q, hold_d, frame_q, frame_d, shift_q, shift_d;
  logic          hold_full_q, hold_full_d, ready_q, ready_d, dacdat_q, dacdat_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;

  sync_edge u_bclk_sync (.clk(clk), .rst(rst), .d(bclk),   .rise(bclk_rise_unused), .fall(bclk_fall));
  sync_edge u_lrc_sync  (.clk(clk), .rst(rst), .d(daclrc), .rise(lrc_rise),         .fall(lrc_fall));

  assign lrc_edge = lrc_fall | lrc_rise;
  assign accept   = audio_in.valid & ready_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    shift_d     = shift_q;
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    dacdat_d    = dacdat_q;

    // Load uses the value held before this edge; a same-cycle accept refills the holding register.
    if (lrc_fall && hold_full_q) begin
      frame_d     = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = audio_in.data;
      hold_full_d = 1'b1;
    end
    ready_d = ~hold_full_d;

    case (state_q)
      IDLE: begin
        dacdat_d = 1'b0;
        if (lrc_fall) state_d = DELAY;
      end
      DELAY: begin
        if (bclk_fall) begin
          dacdat_d = frame_q[N-1];
          shift_d  = frame_q << 1;
          bitcnt_d = CNT_W'(N - 1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bclk_fall) begin
          if (bitcnt_q == '0) begin
            dacdat_d = 1'b0;
            state_d  = PAD;
          end else begin
            dacdat_d = shift_q[N-1];
            shift_d  = shift_q << 1;
            bitcnt_d = bitcnt_q - CNT_W'(1);
          end
        end
      end
      PAD: dacdat_d = 1'b0;
      default: state_d = IDLE;
    endcase

    // The codec owns frame timing: any LRC edge restarts the slot, and its BCLK edge carries no data.
    if (state_q != IDLE && lrc_edge) begin
      state_d  = DELAY;
      dacdat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      ready_q     <= 1'b0;
      dacdat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      ready_q     <= ready_d;
      dacdat_q    <= dacdat_d;
    end
  end

  assign audio_in.ready = ready_q;
  assign dacdat         = dacdat_q;
  assign underflow      = lrc_fall & ~hold_full_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_audio_codec_dac_tx.sv
// Bench for audio_codec_dac_tx: plays the codec (BCLK/LRC), feeds samples, and checks each
// captured slot word, the ready flag and the underflow pulse against a frame-level model.
module tb_audio_codec_dac_tx;
  import audio_pkg::*;

  localparam int N         = 16;
  localparam int BPC       = 32;  // BCLK periods per LRC half-period
  localparam int HALF_BCLK = 6;   // clk periods per BCLK half-period
  localparam int LOAD_LAT  = 4;   // clk edges from an LRC change (driven at negedge) to the frame load

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b1;
  logic daclrc = 1'b1;
  logic dacdat, underflow;
  dac_tx_state_t dbg_state;

  always #5 clk = ~clk;

  dstream #(.N(N)) audio_in_if ();

  audio_codec_dac_tx #(.N(N), .BITS_PER_CH(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .daclrc    (daclrc),
    .audio_in  (audio_in_if),
    .dacdat    (dacdat),
    .underflow (underflow),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [N-1:0] src_q[$];   // samples the source still has to hand over
  logic [N-1:0] exp_q[$];   // accepted but not yet loaded into a frame
  logic [N-1:0] cur_frame = '0;
  logic [N-1:0] inj_data  = '0;
  int  lrc_age  = 99;
  int  rst_rel  = 0;
  bit  acc_pend = 1'b0;
  bit  started  = 1'b0;
  bit  inj_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      if (n_fail <= 25) $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_source();
    audio_in_if.valid = !rst && (src_q.size() > 0);
    audio_in_if.data  = (src_q.size() > 0) ? src_q[0] : '0;
    acc_pend = audio_in_if.valid && audio_in_if.ready;
  endtask

  // One clk period: account for what happened on the posedge just passed, then check and drive.
  task automatic tick();
    @(negedge clk);
    if (!rst) rst_rel++;
    if (lrc_age < 99) lrc_age++;
    if (lrc_age == LOAD_LAT && exp_q.size() > 0) cur_frame = exp_q.pop_front();
    if (acc_pend) exp_q.push_back(src_q.pop_front());
    check("underflow", 32'(underflow), 32'(!rst && lrc_age == LOAD_LAT - 1 && exp_q.size() == 0));
    check("ready", 32'(audio_in_if.ready), 32'(!rst && rst_rel >= 1 && exp_q.size() == 0));
    if (inj_pending && lrc_age == LOAD_LAT - 1) begin
      src_q.push_back(inj_data);
      inj_pending = 1'b0;
    end
    drive_source();
  endtask

  task automatic run_slot(input logic lv, input int rst_at);
    logic [BPC-1:0] word;
    logic [BPC-1:0] exp_word;
    bit skip;
    word = '0;
    skip = 1'b0;
    for (int r = 1; r <= BPC; r++) begin
      bclk = 1'b0;
      if (r == 1) begin
        daclrc = lv;
        if (!lv) begin
          lrc_age = 0;
          started = 1'b1;
        end
      end
      if (r == rst_at) begin
        check("state_mid_slot", 32'(dbg_state), 32'(SHIFT));
        rst = 1'b1;
        #1;
        check("rst_dacdat", 32'(dacdat), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_ready", 32'(audio_in_if.ready), 32'd0);
        exp_q.delete();
        src_q.delete();
        cur_frame = '0;
        started   = 1'b0;
        lrc_age   = 99;
        acc_pend  = 1'b0;
        skip      = 1'b1;
      end
      repeat (HALF_BCLK) tick();
      if (r == rst_at) begin
        rst     = 1'b0;
        rst_rel = 0;
      end
      word = {word[BPC-2:0], dacdat};
      bclk = 1'b1;
      repeat (HALF_BCLK) tick();
    end
    exp_word = started ? {1'b0, cur_frame, {(BPC-N-1){1'b0}}} : '0;
    if (!skip) check(lv ? "right_slot" : "left_slot", 32'(word), 32'(exp_word));
  endtask

  task automatic run_frame(input int rst_at);
    run_slot(1'b0, rst_at);
    run_slot(1'b1, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    audio_in_if.valid = 1'b0;
    audio_in_if.data  = '0;
    repeat (3) tick();
    check("reset_dacdat", 32'(dacdat), 32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
    check("reset_ready", 32'(audio_in_if.ready), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    rst_rel = 0;
    repeat (4) tick();

    // idle frames, no samples
    repeat (2) run_frame(0);

    // single sample, then it repeats under underflow
    src_q.push_back(16'hA5C3);
    repeat (2) run_frame(0);

    // one sample then starvation for two more frames
    src_q.push_back(16'h1234);
    repeat (3) run_frame(0);

    // back-pressure with a source that never drops valid
    src_q.push_back(16'h0001);
    src_q.push_back(16'h8000);
    src_q.push_back(16'h7FFF);
    repeat (4) run_frame(0);

    // accept landing in the same cycle as the left-slot load
    inj_pending = 1'b1;
    inj_data    = 16'($urandom);
    repeat (2) run_frame(0);

    // randomized traffic
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 3) != 0) src_q.push_back(16'($urandom));
      if ($urandom_range(0, 3) == 0) src_q.push_back(16'($urandom));
      run_frame(0);
    end
    for (int k = 0; k < 8 && (src_q.size() > 0 || exp_q.size() > 0); k++) run_frame(0);

    // reset in the middle of a transmitted sample, then a clean restart
    src_q.push_back(16'hBEEF);
    run_frame(10);
    src_q.push_back(16'($urandom));
    repeat (2) run_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
